// File: rtl/prbs7_rx_checker.sv
// PRBS-7 (x^7+x^6+1) receive checker: self-seeds from the RX stream, locks, then counts
// bit/word errors against a free-running local LFSR and drives a stretched LED flag.
module prbs7_rx_checker #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned STRETCH_W  = 22
) (
    input  logic              clk160,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_flag,
    output logic [31:0]       bit_err_cnt,
    output logic [31:0]       word_err_cnt,
    output logic [31:0]       word_cnt,
    output logic              led_err
);

    localparam logic [7:0] LockCnt   = 8'(LOCK_CNT);
    localparam logic [7:0] UnlockCnt = 8'(UNLOCK_CNT);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    // Next DATA_W sequence bits after the 7 most recent ones (seed bit0 newest); MSB earliest.
    function automatic logic [DATA_W-1:0] prbs_next(input logic [6:0] seed);
        logic [6:0]        st;
        logic              nb;
        logic [DATA_W-1:0] w;
        st = seed;
        w  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            nb              = st[6] ^ st[5];
            st              = {st[5:0], nb};
            w[DATA_W-1-i]   = nb;
        end
        return w;
    endfunction

    function automatic logic [5:0] popcount(input logic [DATA_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    state_e                 state_q;
    logic [6:0]             lfsr_q;
    logic [DATA_W-1:0]      prev_q;
    logic                   have_prev_q;
    logic [7:0]             good_run_q;
    logic [7:0]             bad_run_q;
    logic [STRETCH_W-1:0]   stretch_q;

    logic [DATA_W-1:0] hunt_pred;
    logic [DATA_W-1:0] lock_pred;
    logic [5:0]        nbits;
    logic              hunt_match;
    logic              word_err;
    logic              count_en;
    logic [32:0]       bit_sum;

    always_comb begin
        hunt_pred  = prbs_next(prev_q[6:0]);
        lock_pred  = prbs_next(lfsr_q);
        nbits      = popcount(rx_data ^ lock_pred);
        // An all-zero word is the stuck-line case and must never build up a lock.
        hunt_match = have_prev_q && (rx_data == hunt_pred) && (rx_data != '0);
        word_err   = (nbits != 6'd0);
        count_en   = rx_valid && (state_q == StLocked);
        bit_sum    = {1'b0, bit_err_cnt} + 33'(nbits);
    end

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            state_q      <= StHunt;
            lfsr_q       <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            stretch_q    <= '0;
            locked       <= 1'b0;
            err_flag     <= 1'b0;
            bit_err_cnt  <= '0;
            word_err_cnt <= '0;
            word_cnt     <= '0;
            led_err      <= 1'b0;
        end else begin
            err_flag <= 1'b0;

            if (rx_valid) begin
                unique case (state_q)
                    StHunt: begin
                        prev_q      <= rx_data;
                        have_prev_q <= 1'b1;
                        if (!hunt_match) begin
                            good_run_q <= '0;
                        end else if (good_run_q + 8'd1 == LockCnt) begin
                            state_q    <= StLocked;
                            locked     <= 1'b1;
                            lfsr_q     <= rx_data[6:0];
                            good_run_q <= '0;
                            bad_run_q  <= '0;
                        end else begin
                            good_run_q <= good_run_q + 8'd1;
                        end
                    end
                    StLocked: begin
                        // Free-running: never reseeded from rx_data, so errors do not multiply.
                        lfsr_q   <= lock_pred[6:0];
                        err_flag <= word_err;
                        if (!word_err) begin
                            bad_run_q <= '0;
                        end else if (bad_run_q + 8'd1 == UnlockCnt) begin
                            state_q     <= StHunt;
                            locked      <= 1'b0;
                            good_run_q  <= '0;
                            bad_run_q   <= '0;
                            have_prev_q <= 1'b0;
                        end else begin
                            bad_run_q <= bad_run_q + 8'd1;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end

            if (clear_cnt) begin
                bit_err_cnt  <= '0;
                word_err_cnt <= '0;
                word_cnt     <= '0;
            end else if (count_en) begin
                bit_err_cnt <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
                if (word_err && (word_err_cnt != 32'hFFFF_FFFF)) begin
                    word_err_cnt <= word_err_cnt + 32'd1;
                end
                if (word_cnt != 32'hFFFF_FFFF) begin
                    word_cnt <= word_cnt + 32'd1;
                end
            end

            if (count_en && word_err) begin
                stretch_q <= '1;
                led_err   <= 1'b1;
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - STRETCH_W'(1);
                led_err   <= (stretch_q != STRETCH_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_prbs7_rx_checker.sv
// Directed bench for prbs7_rx_checker: lock, single/multi-bit errors, unlock/relock,
// rx_valid gating, clear priority and asynchronous reset.
module tb_prbs7_rx_checker;

    localparam int unsigned StretchW = 6;

    logic        clk160 = 1'b0;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_flag;
    logic [31:0] bit_err_cnt;
    logic [31:0] word_err_cnt;
    logic [31:0] word_cnt;
    logic        led_err;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    bit          gen_q[$];
    logic [15:0] w;

    prbs7_rx_checker #(
        .DATA_W    (16),
        .LOCK_CNT  (16),
        .UNLOCK_CNT(4),
        .STRETCH_W (StretchW)
    ) dut (
        .clk160      (clk160),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .clear_cnt   (clear_cnt),
        .locked      (locked),
        .err_flag    (err_flag),
        .bit_err_cnt (bit_err_cnt),
        .word_err_cnt(word_err_cnt),
        .word_cnt    (word_cnt),
        .led_err     (led_err)
    );

    always #5 clk160 = ~clk160;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: queue holds the last 7 wire bits, oldest at index 0.
    task automatic gen_word(output logic [15:0] o);
        bit nb;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            nb = gen_q[gen_q.size() - 6] ^ gen_q[gen_q.size() - 7];
            gen_q.push_back(nb);
            void'(gen_q.pop_front());
            o = {o[14:0], nb};
        end
    endtask

    task automatic apply(input logic [15:0] d, input logic v, input logic clr);
        rx_data   = d;
        rx_valid  = v;
        clear_cnt = clr;
        @(posedge clk160);
        #1;
        rx_valid  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic send(input logic [15:0] mask);
        logic [15:0] g;
        gen_word(g);
        apply(g ^ mask, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        rx_data   = '0;
        rx_valid  = 1'b0;
        clear_cnt = 1'b0;
        gen_q     = '{1, 1, 1, 1, 1, 1, 1};
        repeat (2) @(posedge clk160);
        #1;
        reset = 1'b0;

        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_bit_err", bit_err_cnt, 32'd0);
        check("rst_word_err", word_err_cnt, 32'd0);
        check("rst_word_cnt", word_cnt, 32'd0);
        check("rst_led", 32'(led_err), 32'd0);

        // Reference generator sanity: first word from all-ones history.
        gen_word(w);
        check("gen_first_word", 32'(w), 32'h0000_020C);
        apply(w, 1'b1, 1'b0);

        // Lock on accepted word 17.
        for (int k = 2; k <= 17; k++) begin
            send(16'h0000);
            if (k == 16) check("lock_w16", 32'(locked), 32'd0);
        end
        check("lock_w17", 32'(locked), 32'd1);
        check("lock_word_cnt", word_cnt, 32'd0);
        check("lock_err_flag", 32'(err_flag), 32'd0);
        repeat (5) send(16'h0000);
        check("clean_word_cnt", word_cnt, 32'd5);
        check("clean_bit_err", bit_err_cnt, 32'd0);
        check("clean_word_err", word_err_cnt, 32'd0);

        // Single flipped bit 5.
        send(16'h0020);
        check("flip5_err_flag", 32'(err_flag), 32'd1);
        check("flip5_bit_err", bit_err_cnt, 32'd1);
        check("flip5_word_err", word_err_cnt, 32'd1);
        check("flip5_locked", 32'(locked), 32'd1);
        check("flip5_led", 32'(led_err), 32'd1);
        check("flip5_word_cnt", word_cnt, 32'd6);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            apply(16'hFFFF, 1'b0, 1'b0);
            if (i == 1) check("idle_err_flag", 32'(err_flag), 32'd0);
            if (!led_err) begin
                n = i;
                break;
            end
        end
        check("led_stretch_len", 32'(n), 32'd63);
        send(16'h0000);
        check("after_flip_err_flag", 32'(err_flag), 32'd0);
        check("after_flip_bit_err", bit_err_cnt, 32'd1);

        // Clear, then 3-bit error word followed by 1-bit error word.
        apply(16'h1234, 1'b0, 1'b1);
        check("clr_bit_err", bit_err_cnt, 32'd0);
        check("clr_word_cnt", word_cnt, 32'd0);
        send(16'h0111);
        send(16'h8000);
        check("multi_bit_err", bit_err_cnt, 32'd4);
        check("multi_word_err", word_err_cnt, 32'd2);
        check("multi_locked", 32'(locked), 32'd1);
        send(16'h0000);

        // Four zero words force unlock; stream keeps running underneath.
        for (int k = 1; k <= 4; k++) begin
            gen_word(w);
            apply(16'h0000, 1'b1, 1'b0);
            if (k == 3) check("zero3_locked", 32'(locked), 32'd1);
        end
        check("zero4_locked", 32'(locked), 32'd0);
        check("zero4_word_err", word_err_cnt, 32'd6);
        check("zero4_word_cnt", word_cnt, 32'd7);
        for (int k = 1; k <= 17; k++) begin
            send(16'h0000);
            if (k == 16) check("relock_w16", 32'(locked), 32'd0);
        end
        check("relock_w17", 32'(locked), 32'd1);
        check("relock_word_cnt", word_cnt, 32'd7);

        // Reset, then lock with rx_valid toggling and garbage on idle cycles.
        reset = 1'b1;
        @(posedge clk160);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            send(16'h0000);
            if (k == 16) check("toggle_w16", 32'(locked), 32'd0);
            if (k < 17) apply(16'hDEAD, 1'b0, 1'b0);
        end
        check("toggle_w17", 32'(locked), 32'd1);
        send(16'h0000);
        apply(16'hBEEF, 1'b0, 1'b0);
        send(16'h0000);
        check("toggle_word_cnt", word_cnt, 32'd2);
        check("toggle_bit_err", bit_err_cnt, 32'd0);
        gen_word(w);
        apply(w ^ 16'h0003, 1'b1, 1'b1);
        check("clr_wins_flag", 32'(err_flag), 32'd1);
        check("clr_wins_bit_err", bit_err_cnt, 32'd0);
        check("clr_wins_word_err", word_err_cnt, 32'd0);
        check("clr_wins_word_cnt", word_cnt, 32'd0);

        // Asynchronous reset mid-stream, sampled before the next edge.
        send(16'h0001);
        check("pre_rst_word_cnt", word_cnt, 32'd1);
        check("pre_rst_led", 32'(led_err), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_err_flag", 32'(err_flag), 32'd0);
        check("arst_bit_err", bit_err_cnt, 32'd0);
        check("arst_word_cnt", word_cnt, 32'd0);
        check("arst_led", 32'(led_err), 32'd0);
        @(posedge clk160);
        #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
